// File: rtl/apb_diag_pkg.sv
// Shared definitions for the diagnostic buffer: register offsets, CTRL/STATUS
// bit positions and the POP read state machine encoding.
package apb_diag_pkg;

   localparam logic [11:0] OFF_CTRL   = 12'h000;
   localparam logic [11:0] OFF_STATUS = 12'h004;
   localparam logic [11:0] OFF_DROP   = 12'h008;
   localparam logic [11:0] OFF_POP    = 12'h00C;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_CLR     = 1;
   localparam int CTRL_OVWR    = 2;
   localparam int CTRL_THR_LSB = 8;
   localparam int CTRL_THR_W   = 8;

   localparam int STAT_EMPTY = 16;
   localparam int STAT_FULL  = 17;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

endpackage

// File: rtl/diag_buf_ram.sv
// DEPTH x 32 simple dual-port RAM: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old contents.
module diag_buf_ram #(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_o <= mem_q[raddr_i];
      end
   end

endmodule

// File: rtl/apb_diag_buffer.sv
// APB4 completer over a circular log buffer fed by hardware event sources.
// CTRL/STATUS/DROP_CNT are zero-wait; a POP read takes one wait state for the RAM read.
module apb_diag_buffer
   import apb_diag_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic        pclk,
   input  logic        preset_n,
   input  logic [11:0] paddr,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] pwdata,
   input  logic [3:0]  pstrb,
   output logic        pready,
   output logic [31:0] prdata,
   output logic        pslverr,
   input  logic        evt_valid,
   input  logic [31:0] evt_data,
   output logic        irq
);

   localparam int AW = $clog2(DEPTH);

   state_e           state_q, state_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [15:0]      drop_q, drop_d;
   logic             en_q, en_d;
   logic             ovwr_q, ovwr_d;
   logic [7:0]       thresh_q, thresh_d;
   logic             irq_q, irq_d;
   logic             live_q;

   logic        access;
   logic        empty, full;
   logic        ram_we, ram_re;
   logic [31:0] ram_rdata;
   logic        do_pop, clr;
   logic        push, grow, ovr, drop;
   logic        rdy_c, err_c;
   logic [31:0] rdata_c;
   logic [31:0] ctrl_rd, status_rd;
   logic        unused_bits;

   // live_q keeps the bus outputs quiet until the first clock after reset release
   assign access = psel && penable && live_q;
   assign empty  = (count_q == '0);
   assign full   = (count_q == CNT_W'(DEPTH));

   always_comb begin
      ctrl_rd                                 = '0;
      ctrl_rd[CTRL_EN]                        = en_q;
      ctrl_rd[CTRL_OVWR]                      = ovwr_q;
      ctrl_rd[CTRL_THR_LSB +: CTRL_THR_W]     = thresh_q;
      status_rd                               = '0;
      status_rd[CNT_W-1:0]                    = count_q;
      status_rd[STAT_EMPTY]                   = empty;
      status_rd[STAT_FULL]                    = full;
   end

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      drop_d   = drop_q;
      en_d     = en_q;
      ovwr_d   = ovwr_q;
      thresh_d = thresh_q;
      ram_re   = 1'b0;
      ram_we   = 1'b0;
      do_pop   = 1'b0;
      clr      = 1'b0;
      rdy_c    = 1'b0;
      err_c    = 1'b0;
      rdata_c  = '0;

      if (access) begin
         if (state_q == WAIT) begin
            rdy_c   = 1'b1;
            rdata_c = ram_rdata;
            do_pop  = 1'b1;
            state_d = IDLE;
         end else if (pwrite) begin
            rdy_c = 1'b1;
            if (paddr == OFF_CTRL) begin
               if (pstrb[0]) begin
                  en_d   = pwdata[CTRL_EN];
                  ovwr_d = pwdata[CTRL_OVWR];
                  clr    = pwdata[CTRL_CLR];
               end
               if (pstrb[1]) begin
                  thresh_d = pwdata[CTRL_THR_LSB +: CTRL_THR_W];
               end
            end else begin
               err_c = 1'b1;
            end
         end else begin
            rdy_c = 1'b1;
            case (paddr)
               OFF_CTRL:   rdata_c = ctrl_rd;
               OFF_STATUS: rdata_c = status_rd;
               OFF_DROP:   rdata_c = {16'h0000, drop_q};
               OFF_POP: begin
                  if (empty) begin
                     err_c = 1'b1;
                  end else begin
                     rdy_c   = 1'b0;
                     ram_re  = 1'b1;
                     state_d = WAIT;
                  end
               end
               default:    err_c = 1'b1;
            endcase
         end
      end

      // A pop commit frees a slot, so a full buffer still takes the push then
      push = en_q && evt_valid && !clr;
      grow = push && (!full || do_pop);
      ovr  = push && full && !do_pop && ovwr_q;
      drop = push && full && !do_pop;

      ram_we = grow || ovr;
      if (ram_we) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop || ovr) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (grow && !do_pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!grow && do_pop) begin
         count_d = count_q - CNT_W'(1);
      end
      if (drop && (drop_q != 16'hFFFF)) begin
         drop_d = drop_q + 16'd1;
      end

      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         drop_d   = '0;
         ram_we   = 1'b0;
      end
   end

   assign irq_d = en_q && (thresh_q != 8'd0) && (32'(count_q) >= 32'(thresh_q));

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= '0;
         en_q     <= 1'b0;
         ovwr_q   <= 1'b0;
         thresh_q <= '0;
         irq_q    <= 1'b0;
         live_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
         en_q     <= en_d;
         ovwr_q   <= ovwr_d;
         thresh_q <= thresh_d;
         irq_q    <= irq_d;
         live_q   <= 1'b1;
      end
   end

   diag_buf_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk_i   (pclk),
      .we_i    (ram_we),
      .waddr_i (wr_ptr_q),
      .wdata_i (evt_data),
      .re_i    (ram_re),
      .raddr_i (rd_ptr_q),
      .rdata_o (ram_rdata)
   );

   assign pready  = rdy_c;
   assign prdata  = rdata_c;
   assign pslverr = err_c;
   assign irq     = irq_q;

   assign unused_bits = ^{pwdata[31:16], pwdata[7:3], pstrb[3:2]};

endmodule

// File: tb/tb_apb_diag_buffer.sv
// Bench for apb_diag_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_apb_diag_buffer;

   localparam int DEPTH = 64;
   localparam logic [11:0] A_CTRL = 12'h000;
   localparam logic [11:0] A_STAT = 12'h004;
   localparam logic [11:0] A_DROP = 12'h008;
   localparam logic [11:0] A_POP  = 12'h00C;

   logic        pclk = 1'b0;
   logic        preset_n = 1'b0;
   logic [11:0] paddr = '0;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [31:0] pwdata = '0;
   logic [3:0]  pstrb = '0;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;
   logic        evt_valid;
   logic [31:0] evt_data;
   logic        irq;

   int checks = 0;
   int failures = 0;

   bit          rand_push = 1'b0;
   logic        force_valid = 1'b0;
   logic [31:0] force_data = '0;

   // reference model state
   logic [31:0] mq[$];
   int          m_drop;
   bit          m_en, m_ovwr, m_wait, m_irq;
   logic [7:0]  m_thr;
   logic [31:0] m_pop_data;

   always #5 pclk = ~pclk;

   apb_diag_buffer #(.DEPTH(DEPTH)) dut (
      .pclk      (pclk),
      .preset_n  (preset_n),
      .paddr     (paddr),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .pwdata    (pwdata),
      .pstrb     (pstrb),
      .pready    (pready),
      .prdata    (prdata),
      .pslverr   (pslverr),
      .evt_valid (evt_valid),
      .evt_data  (evt_data),
      .irq       (irq)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", nm, act, exp, $time);
      end
   endtask

   // event source driver, offset from the APB driver so the two never race
   initial begin
      evt_valid = 1'b0;
      evt_data  = '0;
      forever begin
         @(posedge pclk);
         #2;
         if (rand_push) begin
            evt_valid = ($urandom_range(0, 3) == 0);
            evt_data  = $urandom;
         end else begin
            evt_valid = force_valid;
            evt_data  = force_data;
         end
      end
   end

   // per-cycle compare against the model, then advance the model
   always @(negedge pclk) begin : cmp
      logic [31:0] e_rd;
      logic        e_rdy, e_err, acc, clr, do_pop, push, start, irq_n;
      if (!preset_n) begin
         mq.delete();
         m_drop = 0; m_en = 0; m_ovwr = 0; m_thr = '0;
         m_wait = 0; m_irq = 0; m_pop_data = '0;
         chk("rst_pready", {31'b0, pready}, 32'd0);
         chk("rst_prdata", prdata, 32'd0);
         chk("rst_pslverr", {31'b0, pslverr}, 32'd0);
         chk("rst_irq", {31'b0, irq}, 32'd0);
      end else begin
         e_rd = '0; e_rdy = 0; e_err = 0;
         clr = 0; do_pop = 0; start = 0;
         acc = psel && penable;
         if (acc) begin
            if (m_wait) begin
               e_rdy = 1; e_rd = m_pop_data; do_pop = 1;
            end else if (pwrite) begin
               e_rdy = 1;
               if (paddr == A_CTRL) clr = pstrb[0] && pwdata[1];
               else e_err = 1;
            end else begin
               e_rdy = 1;
               case (paddr)
                  A_CTRL: e_rd = {16'h0, m_thr, 5'b0, m_ovwr, 1'b0, m_en};
                  A_STAT: begin
                     e_rd[6:0] = 7'(mq.size());
                     e_rd[16]  = (mq.size() == 0);
                     e_rd[17]  = (mq.size() == DEPTH);
                  end
                  A_DROP: e_rd = 32'(m_drop);
                  A_POP: begin
                     if (mq.size() == 0) e_err = 1;
                     else begin e_rdy = 0; start = 1; end
                  end
                  default: e_err = 1;
               endcase
            end
         end
         chk("cyc_pready", {31'b0, pready}, {31'b0, e_rdy});
         chk("cyc_prdata", prdata, e_rd);
         chk("cyc_pslverr", {31'b0, pslverr}, {31'b0, e_err});
         chk("cyc_irq", {31'b0, irq}, {31'b0, m_irq});

         irq_n = m_en && (m_thr != 0) && (mq.size() >= int'(m_thr));
         push  = m_en && evt_valid && !clr;
         if (start) m_pop_data = mq[0];
         if (do_pop) begin
            void'(mq.pop_front());
            if (push) mq.push_back(evt_data);
         end else if (push) begin
            if (mq.size() < DEPTH) mq.push_back(evt_data);
            else begin
               if (m_drop < 65535) m_drop++;
               if (m_ovwr) begin
                  void'(mq.pop_front());
                  mq.push_back(evt_data);
               end
            end
         end
         if (clr) begin
            mq.delete();
            m_drop = 0;
         end
         if (acc && !m_wait && pwrite && paddr == A_CTRL) begin
            if (pstrb[0]) begin m_en = pwdata[0]; m_ovwr = pwdata[2]; end
            if (pstrb[1]) m_thr = pwdata[15:8];
         end
         if (start) m_wait = 1;
         else if (do_pop) m_wait = 0;
         m_irq = irq_n;
      end
   end

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic apb_xfer(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                           input logic [3:0] st, input bit push_wait,
                           output logic [31:0] rd, output logic err, output int waits);
      bit done;
      step();
      psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
      step();
      penable = 1;
      waits = 0; done = 0; rd = '0; err = 0;
      for (int i = 0; i < 6 && !done; i++) begin
         @(negedge pclk);
         if (pready) begin
            rd = prdata; err = pslverr; done = 1;
         end else begin
            waits++;
            step();
            if (push_wait) force_valid = 1;
         end
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL apb_timeout addr=0x%03h actual=no_pready required=pready", a);
      end
      step();
      psel = 0; penable = 0; pwrite = 0;
      if (push_wait) force_valid = 0;
      $display("APB %s addr=0x%03h wdata=0x%08h strb=%b rdata=0x%08h err=%0d waits=%0d",
               wr ? "WR" : "RD", a, wd, st, rd, err, waits);
   endtask

   task automatic push_words(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         step();
         force_valid = 1;
         force_data  = base + 32'(i);
      end
      step();
      force_valid = 0;
   endtask

   logic [31:0] rd;
   logic        err;
   int          w;

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [31:0] wd;
      int r;
      preset_n = 0;
      repeat (3) step();
      chk("t1_rst_pready", {31'b0, pready}, 32'd0);
      chk("t1_rst_irq", {31'b0, irq}, 32'd0);
      preset_n = 1;
      step();

      // 1: status after reset
      apb_xfer(1'b0, A_STAT, '0, 4'h0, 0, rd, err, w);
      chk("t1_status", rd, 32'h0001_0000);
      chk("t1_waits", 32'(w), 32'd0);
      chk("t1_err", {31'b0, err}, 32'd0);

      // 2: three pushes, three pops in order
      apb_xfer(1'b1, A_CTRL, 32'h1, 4'hF, 0, rd, err, w);
      push_words(3, 32'hA5A5_0001);
      apb_xfer(1'b0, A_STAT, '0, 4'h0, 0, rd, err, w);
      chk("t2_status3", rd, 32'h0000_0003);
      for (int i = 0; i < 3; i++) begin
         apb_xfer(1'b0, A_POP, '0, 4'h0, 0, rd, err, w);
         chk("t2_pop_data", rd, 32'hA5A5_0001 + 32'(i));
         chk("t2_pop_waits", 32'(w), 32'd1);
      end
      apb_xfer(1'b0, A_STAT, '0, 4'h0, 0, rd, err, w);
      chk("t2_status0", rd, 32'h0001_0000);

      // 3: overflow without and with overwrite
      push_words(DEPTH + 2, 32'h1000_0000);
      apb_xfer(1'b0, A_STAT, '0, 4'h0, 0, rd, err, w);
      chk("t3_status_full", rd, 32'h0002_0040);
      apb_xfer(1'b0, A_DROP, '0, 4'h0, 0, rd, err, w);
      chk("t3_drop", rd, 32'd2);
      apb_xfer(1'b0, A_POP, '0, 4'h0, 0, rd, err, w);
      chk("t3_pop_first", rd, 32'h1000_0000);
      apb_xfer(1'b1, A_CTRL, 32'h3, 4'h1, 0, rd, err, w);
      apb_xfer(1'b1, A_CTRL, 32'h5, 4'h1, 0, rd, err, w);
      push_words(DEPTH + 2, 32'h2000_0000);
      apb_xfer(1'b0, A_POP, '0, 4'h0, 0, rd, err, w);
      chk("t3_pop_ovwr", rd, 32'h2000_0002);
      apb_xfer(1'b0, A_DROP, '0, 4'h0, 0, rd, err, w);
      chk("t3_drop_ovwr", rd, 32'd2);

      // 4: error responses
      apb_xfer(1'b1, A_CTRL, 32'h3, 4'h1, 0, rd, err, w);
      apb_xfer(1'b0, A_POP, '0, 4'h0, 0, rd, err, w);
      chk("t4_pop_empty_err", {31'b0, err}, 32'd1);
      chk("t4_pop_empty_waits", 32'(w), 32'd0);
      apb_xfer(1'b1, A_STAT, 32'hFFFF_FFFF, 4'hF, 0, rd, err, w);
      chk("t4_wr_status_err", {31'b0, err}, 32'd1);
      apb_xfer(1'b0, 12'h010, '0, 4'h0, 0, rd, err, w);
      chk("t4_bad_off_err", {31'b0, err}, 32'd1);
      chk("t4_bad_off_data", rd, 32'd0);
      apb_xfer(1'b0, A_STAT, '0, 4'h0, 0, rd, err, w);
      chk("t4_status", rd, 32'h0001_0000);

      // 5: push during the WAIT cycle of a full buffer, OVWR=0
      apb_xfer(1'b1, A_CTRL, 32'h3, 4'h1, 0, rd, err, w);
      force_data = 32'hDEAD_BEEF;
      push_words(DEPTH, 32'h3000_0000);
      force_data = 32'hDEAD_BEEF;
      apb_xfer(1'b0, A_POP, '0, 4'h0, 1, rd, err, w);
      chk("t5_pop", rd, 32'h3000_0000);
      apb_xfer(1'b0, A_STAT, '0, 4'h0, 0, rd, err, w);
      chk("t5_status", rd, 32'h0002_0040);
      apb_xfer(1'b0, A_DROP, '0, 4'h0, 0, rd, err, w);
      chk("t5_drop", rd, 32'd0);

      // 6: threshold irq, CLR with concurrent push, reset mid-WAIT
      apb_xfer(1'b1, A_CTRL, 32'h0000_0403, 4'h3, 0, rd, err, w);
      push_words(4, 32'h4000_0000);
      chk("t6_irq_low", {31'b0, irq}, 32'd0);
      step();
      chk("t6_irq_high", {31'b0, irq}, 32'd1);
      force_valid = 1; force_data = 32'h5555_AAAA;
      apb_xfer(1'b1, A_CTRL, 32'h0000_FF03, 4'h1, 0, rd, err, w);
      force_valid = 0;
      apb_xfer(1'b0, A_STAT, '0, 4'h0, 0, rd, err, w);
      chk("t6_status_clr", rd, 32'h0001_0000);
      apb_xfer(1'b0, A_DROP, '0, 4'h0, 0, rd, err, w);
      chk("t6_drop_clr", rd, 32'd0);
      chk("t6_irq_fall", {31'b0, irq}, 32'd0);
      apb_xfer(1'b0, A_CTRL, '0, 4'h0, 0, rd, err, w);
      chk("t6_ctrl", rd, 32'h0000_0401);
      push_words(5, 32'h6000_0000);
      step(); step();
      chk("t6_irq_pre_rst", {31'b0, irq}, 32'd1);
      step();
      psel = 1; penable = 0; pwrite = 0; paddr = A_POP;
      step();
      penable = 1;
      step();
      chk("t6_wait_pready", {31'b0, pready}, 32'd1);
      preset_n = 0;
      #1;
      chk("t6_rst_pready", {31'b0, pready}, 32'd0);
      chk("t6_rst_prdata", prdata, 32'd0);
      chk("t6_rst_irq", {31'b0, irq}, 32'd0);
      step();
      psel = 0; penable = 0;
      step();
      preset_n = 1;
      step();
      apb_xfer(1'b0, A_STAT, '0, 4'h0, 0, rd, err, w);
      chk("t6_post_rst_status", rd, 32'h0001_0000);
      apb_xfer(1'b0, A_CTRL, '0, 4'h0, 0, rd, err, w);
      chk("t6_post_rst_ctrl", rd, 32'd0);

      // random traffic against the model
      apb_xfer(1'b1, A_CTRL, 32'h0000_0801, 4'hF, 0, rd, err, w);
      rand_push = 1;
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 9);
         if (r < 4) begin
            apb_xfer(1'b0, A_POP, '0, 4'h0, 0, rd, err, w);
         end else if (r < 6) begin
            apb_xfer(1'b0, A_STAT, '0, 4'h0, 0, rd, err, w);
         end else if (r == 6) begin
            apb_xfer(1'b0, A_DROP, '0, 4'h0, 0, rd, err, w);
         end else if (r == 7) begin
            wd = $urandom;
            wd[0] = ($urandom_range(0, 7) != 0);
            wd[1] = ($urandom_range(0, 15) == 0);
            wd[15:8] = 8'($urandom_range(0, 70));
            apb_xfer(1'b1, A_CTRL, wd, 4'($urandom), 0, rd, err, w);
         end else if (r == 8) begin
            apb_xfer(1'b0, 12'($urandom), '0, 4'h0, 0, rd, err, w);
         end else begin
            apb_xfer(1'b1, 12'($urandom), $urandom, 4'($urandom), 0, rd, err, w);
         end
         repeat ($urandom_range(0, 2)) step();
      end
      rand_push = 0;
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
